// File: rtl/clock_pkg.sv
// Shared types and constants for the clock time-set controller:
// FSM state enum, set_field encodings, BCD limits and BCD increment helpers.
package clock_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      SET_HR  = 2'd1,
      SET_MIN = 2'd2,
      COMMIT  = 2'd3
   } state_t;

   localparam logic [1:0] FIELD_NONE = 2'd0;
   localparam logic [1:0] FIELD_HR   = 2'd1;
   localparam logic [1:0] FIELD_MIN  = 2'd2;

   localparam logic [1:0] HR_MAX_TENS       = 2'd2;
   localparam logic [3:0] HR_MAX_UNITS_AT_2 = 4'd3;
   localparam logic [2:0] MIN_MAX_TENS      = 3'd5;
   localparam logic [3:0] BCD_MAX           = 4'd9;

   typedef struct packed {
      logic [1:0] hr_high;
      logic [3:0] hr_low;
      logic [2:0] min_high;
      logic [3:0] min_low;
   } hhmm_t;

   // Hours roll 23 -> 00; minutes are left untouched.
   function automatic hhmm_t inc_hours(hhmm_t t);
      hhmm_t r;
      r = t;
      if (t.hr_high == HR_MAX_TENS && t.hr_low == HR_MAX_UNITS_AT_2) begin
         r.hr_high = '0;
         r.hr_low  = '0;
      end else if (t.hr_low == BCD_MAX) begin
         r.hr_low  = '0;
         r.hr_high = t.hr_high + 2'd1;
      end else begin
         r.hr_low = t.hr_low + 4'd1;
      end
      return r;
   endfunction

   // Minutes roll 59 -> 00 without carrying into the hours.
   function automatic hhmm_t inc_minutes(hhmm_t t);
      hhmm_t r;
      r = t;
      if (t.min_low == BCD_MAX) begin
         r.min_low  = '0;
         r.min_high = (t.min_high == MIN_MAX_TENS) ? 3'd0 : t.min_high + 3'd1;
      end else begin
         r.min_low = t.min_low + 4'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/btn_edge_repeat.sv
// Rising-edge detector for a debounced button, with an optional hold-to-repeat
// pulse generator compiled in only when AUTO_REPEAT_EN is defined.
module btn_edge_repeat #(
   parameter bit          REPEAT_ON  = 1'b0,
   parameter int unsigned REPEAT_DLY = 50_000_000,
   parameter int unsigned REPEAT_PER = 12_500_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic pulse
);

   logic prev;
   logic rise;

   // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) prev <= 1'b0;
      else      prev <= btn;
   end

   assign rise = btn & ~prev;

   if (REPEAT_ON && (REPEAT_PER == 0 || REPEAT_DLY < REPEAT_PER)) begin : g_bad_repeat_cfg
      $error("btn_edge_repeat: REPEAT_PER must be nonzero and not exceed REPEAT_DLY");
   end

`ifdef AUTO_REPEAT_EN
   if (REPEAT_ON) begin : g_repeat
      logic [31:0] hold_cnt;
      logic        fire;

      // hold_cnt equals the number of cycles since the rising edge; after a
      // repeat it is rewound so the next one lands REPEAT_PER cycles later.
      assign fire = btn && prev && (hold_cnt == REPEAT_DLY);

      always_ff @(posedge clk or negedge rst) begin
         if (!rst)              hold_cnt <= '0;
         else if (!btn)         hold_cnt <= '0;
         else if (!prev)        hold_cnt <= 32'd1;
         else if (fire)         hold_cnt <= REPEAT_DLY - REPEAT_PER + 32'd1;
         else                   hold_cnt <= hold_cnt + 32'd1;
      end

      assign pulse = rise | fire;
   end else begin : g_no_repeat
      assign pulse = rise;
   end
`else
   assign pulse = rise;
`endif

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-set controller: RUN / SET_HR / SET_MIN / COMMIT sequencing, BCD shadow
// editing, timeout abort and display blink. Optional hold-to-repeat: AUTO_REPEAT_EN.
module clock_set_ctrl
   import clock_pkg::*;
#(
   parameter int unsigned TIMEOUT_S  = 30,
   parameter int unsigned REPEAT_DLY = 50_000_000,
   parameter int unsigned REPEAT_PER = 12_500_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic       mode_btn,
   input  logic       inc_btn,
   input  logic [1:0] cur_hr_high,
   input  logic [3:0] cur_hr_low,
   input  logic [2:0] cur_min_high,
   input  logic [3:0] cur_min_low,
   output logic       run_en,
   output logic       load,
   output logic [1:0] load_hr_high,
   output logic [3:0] load_hr_low,
   output logic [2:0] load_min_high,
   output logic [3:0] load_min_low,
   output logic [1:0] set_field,
   output logic       blink
);

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_S - 1);

   state_t     state, state_nx;
   hhmm_t      shadow;
   logic [7:0] tmo_cnt;
   logic       blink_q;
   logic       mode_ev, inc_ev, in_set, any_ev, timeout_hit;

   btn_edge_repeat #(
      .REPEAT_ON (1'b0),
      .REPEAT_DLY(REPEAT_DLY),
      .REPEAT_PER(REPEAT_PER)
   ) u_mode (
      .clk  (clk),
      .rst  (rst),
      .btn  (mode_btn),
      .pulse(mode_ev)
   );

   btn_edge_repeat #(
      .REPEAT_ON (1'b1),
      .REPEAT_DLY(REPEAT_DLY),
      .REPEAT_PER(REPEAT_PER)
   ) u_inc (
      .clk  (clk),
      .rst  (rst),
      .btn  (inc_btn),
      .pulse(inc_ev)
   );

   assign in_set      = (state == SET_HR) || (state == SET_MIN);
   assign any_ev      = mode_ev | inc_ev;
   assign timeout_hit = in_set && !any_ev && tick_1hz && (tmo_cnt == TMO_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= RUN;
      else      state <= state_nx;
   end

   always_comb begin
      // NOTE: default assignment first, so no path through the case infers a latch.
      state_nx = state;
      unique case (state)
         RUN:     if (mode_ev) state_nx = SET_HR;
         SET_HR:  if (mode_ev) state_nx = SET_MIN; else if (timeout_hit) state_nx = RUN;
         SET_MIN: if (mode_ev) state_nx = COMMIT;  else if (timeout_hit) state_nx = RUN;
         COMMIT:  state_nx = RUN;
      endcase
   end

   always_comb begin
      run_en    = (state == RUN);
      load      = (state == COMMIT);
      set_field = FIELD_NONE;
      if (state == SET_HR)  set_field = FIELD_HR;
      if (state == SET_MIN) set_field = FIELD_MIN;
   end

   // Mode beats a simultaneous inc; the shadow survives a timeout but is never loaded.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shadow  <= '0;
         tmo_cnt <= '0;
         blink_q <= 1'b0;
      end else begin
         if (state == RUN && mode_ev)
            shadow <= '{hr_high: cur_hr_high, hr_low: cur_hr_low,
                        min_high: cur_min_high, min_low: cur_min_low};
         else if (state == SET_HR && !mode_ev && inc_ev)
            shadow <= inc_hours(shadow);
         else if (state == SET_MIN && !mode_ev && inc_ev)
            shadow <= inc_minutes(shadow);

         if (!in_set || any_ev) tmo_cnt <= '0;
         else if (tick_1hz)     tmo_cnt <= tmo_cnt + 8'd1;

         if (state_nx != SET_HR && state_nx != SET_MIN) blink_q <= 1'b0;
         else if (state_nx != state)                    blink_q <= 1'b1;
         else if (tick_1hz)                             blink_q <= ~blink_q;
      end
   end

   assign load_hr_high  = shadow.hr_high;
   assign load_hr_low   = shadow.hr_low;
   assign load_min_high = shadow.min_high;
   assign load_min_low  = shadow.min_low;
   assign blink         = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: cycle model in plain integer arithmetic
// plus directed scenarios with literal expectations.
module tb_clock_set_ctrl;

   localparam int TMO = 3;
   localparam int DLY = 10;
   localparam int PER = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick_1hz = 1'b0, mode_btn = 1'b0, inc_btn = 1'b0;
   logic [1:0] cur_hr_high = '0;
   logic [3:0] cur_hr_low = '0;
   logic [2:0] cur_min_high = '0;
   logic [3:0] cur_min_low = '0;
   logic       run_en, load, blink;
   logic [1:0] load_hr_high, set_field;
   logic [3:0] load_hr_low, load_min_low;
   logic [2:0] load_min_high;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   clock_set_ctrl #(.TIMEOUT_S(TMO), .REPEAT_DLY(DLY), .REPEAT_PER(PER)) dut (
      .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .mode_btn(mode_btn), .inc_btn(inc_btn),
      .cur_hr_high(cur_hr_high), .cur_hr_low(cur_hr_low),
      .cur_min_high(cur_min_high), .cur_min_low(cur_min_low),
      .run_en(run_en), .load(load),
      .load_hr_high(load_hr_high), .load_hr_low(load_hr_low),
      .load_min_high(load_min_high), .load_min_low(load_min_low),
      .set_field(set_field), .blink(blink)
   );

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef enum {M_RUN, M_HR, M_MIN, M_COMMIT} mstate_t;
   typedef struct {
      mstate_t st;
      int      hr;
      int      mins;
      int      tmo;
      int      held;
      bit      blink;
      bit      pm;
      bit      pi;
   } model_t;

   model_t m;

   function automatic model_t step(model_t c, bit md, bit ic, bit tk, int cur_h, int cur_m);
      model_t n;
      bit me, ie, rep, incv;
      n    = c;
      me   = md && !c.pm;
      ie   = ic && !c.pi;
      rep  = 1'b0;
      n.pm = md;
      n.pi = ic;
      n.held = ic ? c.held + 1 : 0;
`ifdef AUTO_REPEAT_EN
      if (ic && c.pi && (n.held - 1) >= DLY && ((n.held - 1 - DLY) % PER) == 0) rep = 1'b1;
`endif
      incv = ie || rep;
      case (c.st)
         M_RUN: if (me) begin
            n.st = M_HR; n.hr = cur_h; n.mins = cur_m; n.blink = 1'b1; n.tmo = 0;
         end
         M_HR, M_MIN: begin
            if (me) begin
               n.st    = (c.st == M_HR) ? M_MIN : M_COMMIT;
               n.blink = (c.st == M_HR);
               n.tmo   = 0;
            end else begin
               if (incv) begin
                  if (c.st == M_HR) n.hr = (c.hr + 1) % 24;
                  else              n.mins = (c.mins + 1) % 60;
                  n.tmo = 0;
               end
               if (tk) begin
                  n.blink = !c.blink;
                  if (!incv) n.tmo = c.tmo + 1;
               end
               if (n.tmo == TMO) begin
                  n.st = M_RUN; n.blink = 1'b0; n.tmo = 0;
               end
            end
         end
         M_COMMIT: begin
            n.st = M_RUN; n.blink = 1'b0;
         end
      endcase
      return n;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst)
         m <= '{st: M_RUN, hr: 0, mins: 0, tmo: 0, held: 0, blink: 1'b0, pm: 1'b0, pi: 1'b0};
      else
         m <= step(m, mode_btn, inc_btn, tick_1hz,
                   int'(cur_hr_high) * 10 + int'(cur_hr_low),
                   int'(cur_min_high) * 10 + int'(cur_min_low));
   end

   // ---------------- per-cycle compare ----------------
   always @(posedge clk) begin
      #2;
      check("run_en",    int'(run_en),    int'(m.st == M_RUN));
      check("load",      int'(load),      int'(m.st == M_COMMIT));
      check("set_field", int'(set_field), (m.st == M_HR) ? 1 : (m.st == M_MIN) ? 2 : 0);
      check("blink",     int'(blink),     int'(m.blink));
      if (m.st != M_RUN) begin
         check("load_hr_high",  int'(load_hr_high),  m.hr / 10);
         check("load_hr_low",   int'(load_hr_low),   m.hr % 10);
         check("load_min_high", int'(load_min_high), m.mins / 10);
         check("load_min_low",  int'(load_min_low),  m.mins % 10);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_cur(input int hh, input int mm);
      cur_hr_high  = 2'(hh / 10);
      cur_hr_low   = 4'(hh % 10);
      cur_min_high = 3'(mm / 10);
      cur_min_low  = 4'(mm % 10);
   endtask

   // One high sample followed by one low sample; returns on a negedge.
   task automatic drive(input bit md, input bit ic, input bit tk);
      mode_btn = md; inc_btn = ic; tick_1hz = tk;
      @(negedge clk);
      mode_btn = 1'b0; inc_btn = 1'b0; tick_1hz = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_time(input string tag, input int hh, input int mm);
      check({tag, "_hr"},  int'(load_hr_high) * 10 + int'(load_hr_low),   hh);
      check({tag, "_min"}, int'(load_min_high) * 10 + int'(load_min_low), mm);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_run_en"},    int'(run_en),    1);
      check({tag, "_load"},      int'(load),      0);
      check({tag, "_set_field"}, int'(set_field), 0);
      check({tag, "_blink"},     int'(blink),     0);
      check_time(tag, 0, 0);
   endtask

   // Mode press from SET_MIN: exactly one load cycle carrying hh:mm.
   task automatic commit_and_check(input string tag, input int hh, input int mm);
      mode_btn = 1'b1;
      @(negedge clk);
      mode_btn = 1'b0;
      check({tag, "_load_hi"},   int'(load),   1);
      check({tag, "_run_en_lo"}, int'(run_en), 0);
      check_time(tag, hh, mm);
      @(negedge clk);
      check({tag, "_load_lo"},   int'(load),      0);
      check({tag, "_run_en_hi"}, int'(run_en),    1);
      check({tag, "_field0"},    int'(set_field), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed scenarios ----------------
   initial begin
      set_cur(12, 34);
      #1 rst = 1'b0;
      #11;
      check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Enter SET_HR with live time 12:34.
      drive(1, 0, 0);
      check("enter_field",  int'(set_field), 1);
      check("enter_run_en", int'(run_en),    0);
      check("enter_blink",  int'(blink),     1);
      check_time("enter", 12, 34);

      // Hours 12 -> 22 -> 23 -> 00.
      for (int i = 0; i < 10; i++) drive(0, 1, 0);
      check_time("hr22", 22, 34);
      drive(0, 1, 0);
      check_time("hr23", 23, 34);
      drive(0, 1, 0);
      check_time("hr00", 0, 34);

      // Minutes 34 -> 58 -> 59 -> 00, hours stay 00.
      drive(1, 0, 0);
      check("min_field", int'(set_field), 2);
      for (int i = 0; i < 24; i++) drive(0, 1, 0);
      check_time("min58", 0, 58);
      drive(0, 1, 0);
      check_time("min59", 0, 59);
      drive(0, 1, 0);
      check_time("min00", 0, 0);
      commit_and_check("commit0000", 0, 0);

      // Commit of an unedited 07:45.
      set_cur(7, 45);
      drive(1, 0, 0);
      drive(1, 0, 0);
      commit_and_check("commit0745", 7, 45);

      // Timeout with an inc edge (plus coincident tick) restarting the count.
      set_cur(9, 15);
      drive(1, 0, 0);
      drive(0, 0, 1);
      check("tmo_blink1", int'(blink), 0);
      drive(0, 0, 1);
      check("tmo_blink2", int'(blink), 1);
      drive(0, 1, 1);
      check("tmo_blink3", int'(blink), 0);
      check_time("tmo_inc", 10, 15);
      drive(0, 0, 1);
      drive(0, 0, 1);
      check("tmo_still_set", int'(set_field), 1);
      drive(0, 0, 1);
      check("tmo_run_en", int'(run_en),    1);
      check("tmo_field",  int'(set_field), 0);
      check("tmo_blink",  int'(blink),     0);
      check("tmo_load",   int'(load),      0);

      // Simultaneous mode and inc edges: mode wins, hours unchanged.
      drive(1, 0, 0);
      drive(1, 1, 0);
      check("simul_field", int'(set_field), 2);
      check_time("simul", 9, 15);

      // Asynchronous reset in the middle of SET_MIN.
      rst = 1'b0;
      #1;
      check_reset_outputs("midreset");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Hold inc for 23 samples in SET_MIN starting at 00.
      set_cur(10, 0);
      drive(1, 0, 0);
      drive(1, 0, 0);
      inc_btn = 1'b1;
      repeat (23) @(negedge clk);
      inc_btn = 1'b0;
`ifdef AUTO_REPEAT_EN
      check_time("hold", 10, 5);
`else
      check_time("hold", 10, 1);
`endif
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
